ibex_compressed_encoder: RTL and testbench

Streaming RV32 → RVC compressor and parcel packer. Accepts one 32-bit instruction per cycle on a valid/ready handshake and replaces each eligible instruction with its 16-bit RVC equivalent. It packs the resulting 16/32-bit parcels into little-endian 32-bit memory words on a second valid/ready handshake. It sits between the instruction generator/loader and the instruction memory write port, producing images that the core's compressed decoder expands back exactly.

---
 rtl/ibex_compressed_encoder.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_ibex_compressed_encoder.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_compressed_encoder.sv
`default_nettype none
// ============================================================================
// ibex_compressed_encoder : streaming RV32 -> RVC compressor and word packer.
// Optional macro IBEX_CENC_STATS_EN adds accepted/compressed counters.
// Revision : 1.0
// ============================================================================
module ibex_compressed_encoder #(
  parameter bit RV32E = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  input  logic [31:0] instr_i,
  input  logic        flush_i,
  output logic        word_valid_o,
  input  logic        word_ready_i,
  output logic [31:0] word_o,
  output logic        busy_o
`ifdef IBEX_CENC_STATS_EN
  ,
  output logic [31:0] stat_total_o,
  output logic [31:0] stat_comp_o
`endif
);

  localparam logic [6:0] OP_IMM   = 7'h13;
  localparam logic [6:0] OP_REG   = 7'h33;
  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_JALR  = 7'h67;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_HALF  = 1'b1;

  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [11:0] imm_i;
  logic [11:0] imm_s;

  assign opcode = instr_i[6:0];
  assign rd     = instr_i[11:7];
  assign funct3 = instr_i[14:12];
  assign rs1    = instr_i[19:15];
  assign rs2    = instr_i[24:20];
  assign funct7 = instr_i[31:25];
  assign imm_i  = instr_i[31:20];
  assign imm_s  = {instr_i[31:25], instr_i[11:7]};

  function automatic logic reg_ok(input logic [4:0] r);
    reg_ok = !RV32E || !r[4];
  endfunction

  function automatic logic is_prime(input logic [4:0] r);
    is_prime = (r[4:3] == 2'b01);
  endfunction

  logic       imm_fits6;
  logic       arith_ok;
  logic [1:0] arith_f2;

  assign imm_fits6 = (imm_i[11:5] == 7'h00) || (imm_i[11:5] == 7'h7F);

  always_comb begin
    arith_ok = 1'b0;
    arith_f2 = 2'b00;
    if (opcode == OP_REG && rd == rs1 && is_prime(rd) && is_prime(rs2)) begin
      if (funct7 == 7'h20 && funct3 == 3'b000) begin
        arith_ok = 1'b1;
        arith_f2 = 2'b00;
      end else if (funct7 == 7'h00) begin
        case (funct3)
          3'b100:  begin arith_ok = 1'b1; arith_f2 = 2'b01; end
          3'b110:  begin arith_ok = 1'b1; arith_f2 = 2'b10; end
          3'b111:  begin arith_ok = 1'b1; arith_f2 = 2'b11; end
          default: begin arith_ok = 1'b0; arith_f2 = 2'b00; end
        endcase
      end
    end
  end

  logic        conv_ok;
  logic [15:0] conv_parcel;

  // First match wins; every candidate re-checks its own opcode.
  always_comb begin
    conv_ok     = 1'b0;
    conv_parcel = 16'h0000;
    if (instr_i[1:0] == 2'b11) begin
      if (opcode == OP_IMM && funct3 == 3'b000 && rd != 5'd0 && rs1 == rd &&
          imm_i != 12'd0 && imm_fits6 && reg_ok(rd)) begin
        conv_ok     = 1'b1;
        conv_parcel = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
      end else if (opcode == OP_IMM && funct3 == 3'b000 && rd != 5'd0 && rs1 == 5'd0 &&
                   imm_fits6 && reg_ok(rd)) begin
        conv_ok     = 1'b1;
        conv_parcel = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
      end else if (opcode == OP_IMM && funct3 == 3'b001 && funct7 == 7'h00 && rd != 5'd0 &&
                   rs1 == rd && rs2 != 5'd0 && reg_ok(rd)) begin
        conv_ok     = 1'b1;
        conv_parcel = {3'b000, 1'b0, rd, rs2, 2'b10};
      end else if (opcode == OP_REG && funct3 == 3'b000 && funct7 == 7'h00 && rd != 5'd0 &&
                   rs2 != 5'd0 && rs1 == 5'd0 && reg_ok(rd) && reg_ok(rs2)) begin
        conv_ok     = 1'b1;
        conv_parcel = {4'b1000, rd, rs2, 2'b10};
      end else if (opcode == OP_REG && funct3 == 3'b000 && funct7 == 7'h00 && rd != 5'd0 &&
                   rs2 != 5'd0 && rs1 == rd && reg_ok(rd) && reg_ok(rs2)) begin
        conv_ok     = 1'b1;
        conv_parcel = {4'b1001, rd, rs2, 2'b10};
      end else if (arith_ok) begin
        conv_ok     = 1'b1;
        conv_parcel = {3'b100, 1'b0, 2'b11, rd[2:0], arith_f2, rs2[2:0], 2'b01};
      end else if (opcode == OP_LOAD && funct3 == 3'b010 && is_prime(rd) && is_prime(rs1) &&
                   imm_i[1:0] == 2'b00 && imm_i[11:7] == 5'd0) begin
        conv_ok     = 1'b1;
        conv_parcel = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
      end else if (opcode == OP_LOAD && funct3 == 3'b010 && rs1 == 5'd2 && rd != 5'd0 &&
                   imm_i[1:0] == 2'b00 && imm_i[11:8] == 4'd0 && reg_ok(rd)) begin
        conv_ok     = 1'b1;
        conv_parcel = {3'b010, imm_i[5], rd, imm_i[4:2], imm_i[7:6], 2'b10};
      end else if (opcode == OP_STORE && funct3 == 3'b010 && is_prime(rs2) && is_prime(rs1) &&
                   imm_s[1:0] == 2'b00 && imm_s[11:7] == 5'd0) begin
        conv_ok     = 1'b1;
        conv_parcel = {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
      end else if (opcode == OP_STORE && funct3 == 3'b010 && rs1 == 5'd2 &&
                   imm_s[1:0] == 2'b00 && imm_s[11:8] == 4'd0 && reg_ok(rs2)) begin
        conv_ok     = 1'b1;
        conv_parcel = {3'b110, imm_s[5:2], imm_s[7:6], rs2, 2'b10};
      end else if (opcode == OP_JALR && funct3 == 3'b000 && imm_i == 12'd0 && rs1 != 5'd0 &&
                   reg_ok(rs1) && (rd == 5'd0 || rd == 5'd1)) begin
        conv_ok     = 1'b1;
        conv_parcel = {3'b100, rd[0], rs1, 5'd0, 2'b10};
      end else if (instr_i == 32'h0010_0073) begin
        conv_ok     = 1'b1;
        conv_parcel = 16'h9002;
      end
    end
  end

  logic        in_is16;
  logic [31:0] in_parcel;

  assign in_is16   = (instr_i[1:0] != 2'b11) || conv_ok;
  assign in_parcel = (instr_i[1:0] != 2'b11) ? {16'h0000, instr_i[15:0]} :
                     conv_ok                 ? {16'h0000, conv_parcel}   : instr_i;

  logic        s1_valid;
  logic        s1_is16;
  logic [31:0] s1_parcel;
  logic [0:0]  state_q;
  logic [0:0]  state_d;
  logic [15:0] pend_q;
  logic        out_valid;
  logic [31:0] out_word;

  logic s1_makes_word;
  logic out_free;
  logic s1_advance;
  logic accept;
  logic flush_fire;

  assign s1_makes_word = !(s1_is16 && state_q == ST_EMPTY);
  assign out_free      = !out_valid || word_ready_i;
  assign s1_advance    = s1_valid && (!s1_makes_word || out_free);
  assign instr_ready_o = !s1_valid || s1_advance;
  assign accept        = instr_valid_i && instr_ready_o;
  assign flush_fire    = flush_i && !s1_valid && state_q == ST_HALF && out_free;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid  <= 1'b0;
      s1_is16   <= 1'b0;
      s1_parcel <= 32'h0;
    end else if (accept) begin
      s1_valid  <= 1'b1;
      s1_is16   <= in_is16;
      s1_parcel <= in_parcel;
    end else if (s1_advance) begin
      s1_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (s1_advance) begin
      if (s1_is16) begin
        state_d = (state_q == ST_EMPTY) ? ST_HALF : ST_EMPTY;
      end
    end else if (flush_fire) begin
      state_d = ST_EMPTY;
    end
  end

  logic        word_load;
  logic [31:0] word_next;
  logic        pend_load;
  logic [15:0] pend_next;

  always_comb begin
    word_load = 1'b0;
    word_next = 32'h0;
    pend_load = 1'b0;
    pend_next = 16'h0;
    if (s1_advance) begin
      if (state_q == ST_EMPTY) begin
        if (s1_is16) begin
          pend_load = 1'b1;
          pend_next = s1_parcel[15:0];
        end else begin
          word_load = 1'b1;
          word_next = s1_parcel;
        end
      end else begin
        word_load = 1'b1;
        word_next = {s1_parcel[15:0], pend_q};
        if (!s1_is16) begin
          pend_load = 1'b1;
          pend_next = s1_parcel[31:16];
        end
      end
    end else if (flush_fire) begin
      // Pad the odd halfword with c.nop so the image stays decodable.
      word_load = 1'b1;
      word_next = {16'h0001, pend_q};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid <= 1'b0;
      out_word  <= 32'h0;
      pend_q    <= 16'h0;
    end else begin
      if (word_load) begin
        out_valid <= 1'b1;
        out_word  <= word_next;
      end else if (word_ready_i) begin
        out_valid <= 1'b0;
      end
      if (pend_load) begin
        pend_q <= pend_next;
      end
    end
  end

  assign word_valid_o = out_valid;
  assign word_o       = out_word;
  assign busy_o       = s1_valid || (state_q == ST_HALF) || out_valid;

`ifdef IBEX_CENC_STATS_EN
  logic [31:0] stat_total_q;
  logic [31:0] stat_comp_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_total_q <= 32'h0;
      stat_comp_q  <= 32'h0;
    end else if (accept) begin
      stat_total_q <= stat_total_q + 32'd1;
      if (conv_ok) begin
        stat_comp_q <= stat_comp_q + 32'd1;
      end
    end
  end

  assign stat_total_o = stat_total_q;
  assign stat_comp_o  = stat_comp_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ibex_compressed_encoder.sv
`default_nettype none
// Bench for ibex_compressed_encoder: directed packing cases plus a random stream
// checked by re-expanding the packed halfwords against the original instructions.
module tb_ibex_compressed_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = 32'h0;
  logic        flush = 1'b0;
  logic        word_valid;
  logic        word_ready = 1'b1;
  logic [31:0] word;
  logic        busy;
`ifdef IBEX_CENC_STATS_EN
  logic [31:0] stat_total;
  logic [31:0] stat_comp;
`endif

  int passed = 0;
  int total  = 0;
  logic [31:0] got[$];

  ibex_compressed_encoder dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .instr_valid_i (instr_valid),
    .instr_ready_o (instr_ready),
    .instr_i       (instr),
    .flush_i       (flush),
    .word_valid_o  (word_valid),
    .word_ready_i  (word_ready),
    .word_o        (word),
    .busy_o        (busy)
`ifdef IBEX_CENC_STATS_EN
    ,
    .stat_total_o  (stat_total),
    .stat_comp_o   (stat_comp)
`endif
  );

  always #5 clk = ~clk;

  // Record every consumed word, sampled just before the rising edge.
  initial forever begin
    @(negedge clk);
    #4;
    if (rst_n && word_valid && word_ready) got.push_back(word);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got %0d words", got.size());
    $fatal(1, "watchdog");
  end

  // ---------------- reference: eligibility from the compression rules ----------------
  function automatic bit prime(input int r);
    return r >= 8 && r <= 15;
  endfunction

  function automatic bit eligible(input logic [31:0] x);
    int op, rd, rs1, rs2, f3, f7, ii, is;
    op = int'(x[6:0]); rd = int'(x[11:7]); f3 = int'(x[14:12]);
    rs1 = int'(x[19:15]); rs2 = int'(x[24:20]); f7 = int'(x[31:25]);
    ii = int'($signed(x[31:20]));
    is = int'($signed({x[31:25], x[11:7]}));
    if (x[1:0] != 2'b11) return 1'b1;
    case (op)
      'h13: begin
        if (f3 == 0 && rd != 0 && rs1 == rd && ii != 0 && ii >= -32 && ii <= 31) return 1'b1;
        if (f3 == 0 && rd != 0 && rs1 == 0 && ii >= -32 && ii <= 31) return 1'b1;
        if (f3 == 1 && f7 == 0 && rd != 0 && rs1 == rd && rs2 > 0 && rs2 < 32) return 1'b1;
        return 1'b0;
      end
      'h33: begin
        if (f3 == 0 && f7 == 0 && rd != 0 && rs2 != 0 && (rs1 == 0 || rs1 == rd)) return 1'b1;
        if (rd == rs1 && prime(rd) && prime(rs2) &&
            ((f7 == 'h20 && f3 == 0) || (f7 == 0 && (f3 == 4 || f3 == 6 || f3 == 7)))) return 1'b1;
        return 1'b0;
      end
      'h03: begin
        if (f3 != 2 || ii % 4 != 0) return 1'b0;
        if (prime(rd) && prime(rs1) && ii >= 0 && ii <= 124) return 1'b1;
        return rs1 == 2 && rd != 0 && ii >= 0 && ii <= 252;
      end
      'h23: begin
        if (f3 != 2 || is % 4 != 0) return 1'b0;
        if (prime(rs2) && prime(rs1) && is >= 0 && is <= 124) return 1'b1;
        return rs1 == 2 && is >= 0 && is <= 252;
      end
      'h67: return f3 == 0 && ii == 0 && rs1 != 0 && (rd == 0 || rd == 1);
      'h73: return x == 32'h0010_0073;
      default: return 1'b0;
    endcase
  endfunction

  // ---------------- reference: the compressed decoder (RVC -> RV32) ----------------
  function automatic logic [31:0] expand16(input logic [15:0] c);
    logic [4:0]  rd, rs2, rdp, rs1p;
    logic [11:0] imm6, off;
    rd = c[11:7]; rs2 = c[6:2];
    rdp = {2'b01, c[4:2]}; rs1p = {2'b01, c[9:7]};
    imm6 = {{6{c[12]}}, c[12], c[6:2]};
    case ({c[15:13], c[1:0]})
      5'b000_01: return {imm6, rd, 3'b000, rd, 7'h13};
      5'b010_01: return {imm6, 5'd0, 3'b000, rd, 7'h13};
      5'b100_01: begin
        if (c[12] == 1'b0 && c[11:10] == 2'b11) begin
          case (c[6:5])
            2'b00: return {7'h20, rdp, rs1p, 3'b000, rs1p, 7'h33};
            2'b01: return {7'h00, rdp, rs1p, 3'b100, rs1p, 7'h33};
            2'b10: return {7'h00, rdp, rs1p, 3'b110, rs1p, 7'h33};
            default: return {7'h00, rdp, rs1p, 3'b111, rs1p, 7'h33};
          endcase
        end
        return 32'hFFFF_FFFF;
      end
      5'b010_00: begin
        off = {5'd0, c[5], c[12:10], c[6], 2'b00};
        return {off, rs1p, 3'b010, rdp, 7'h03};
      end
      5'b110_00: begin
        off = {5'd0, c[5], c[12:10], c[6], 2'b00};
        return {off[11:5], rdp, rs1p, 3'b010, off[4:0], 7'h23};
      end
      5'b000_10: return c[12] ? 32'hFFFF_FFFF : {7'h00, c[6:2], rd, 3'b001, rd, 7'h13};
      5'b010_10: begin
        off = {4'd0, c[3:2], c[12], c[6:4], 2'b00};
        return {off, 5'd2, 3'b010, rd, 7'h03};
      end
      5'b100_10: begin
        if (!c[12]) return (rs2 == 0) ? {12'h0, rd, 3'b000, 5'd0, 7'h67}
                                      : {7'h00, rs2, 5'd0, 3'b000, rd, 7'h33};
        if (rs2 == 0 && rd == 0) return 32'h0010_0073;
        if (rs2 == 0) return {12'h0, rd, 3'b000, 5'd1, 7'h67};
        return {7'h00, rs2, rd, 3'b000, rd, 7'h33};
      end
      5'b110_10: begin
        off = {4'd0, c[8:7], c[12:9], 2'b00};
        return {off[11:5], rs2, 5'd2, 3'b010, off[4:0], 7'h23};
      end
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 5))
      0: return 5'($urandom_range(0, 31));
      1: return 5'd0;
      2: return 5'd2;
      default: return 5'($urandom_range(8, 15));
    endcase
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    logic [2:0]  f3;
    logic [31:0] r;
    int          s;
    rd  = pick_reg();
    rs2 = pick_reg();
    rs1 = ($urandom_range(0, 2) == 0) ? pick_reg() : rd;
    imm = ($urandom_range(0, 3) == 0) ? 12'($urandom()) : 12'(int'($urandom_range(0, 80)) - 40);
    r   = $urandom();
    s   = int'($urandom_range(0, 3));
    case ($urandom_range(0, 11))
      0: begin
        if ($urandom_range(0, 2) == 0) rs1 = 5'd0;
        return {imm, rs1, 3'b000, rd, 7'h13};
      end
      1: return {7'h00, 5'($urandom_range(0, 31)), rs1, 3'b001, rd, 7'h13};
      2: begin
        if ($urandom_range(0, 1) == 0) rs1 = 5'd0;
        return {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
      end
      3: begin
        f3 = (s == 0) ? 3'd0 : (s == 1) ? 3'd4 : (s == 2) ? 3'd6 : 3'd7;
        return {(s == 0) ? 7'h20 : 7'h00, rs2, rs1, f3, rd, 7'h33};
      end
      4: begin
        imm = 12'(4 * $urandom_range(0, 66)) | (($urandom_range(0, 7) == 0) ? 12'd1 : 12'd0);
        if ($urandom_range(0, 1) == 0) rs1 = 5'd2;
        return {imm, rs1, 3'b010, rd, 7'h03};
      end
      5: begin
        imm = 12'(4 * $urandom_range(0, 66)) | (($urandom_range(0, 7) == 0) ? 12'd2 : 12'd0);
        if ($urandom_range(0, 1) == 0) rs1 = 5'd2;
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
      end
      6: begin
        rd = (s == 0) ? 5'd0 : (s == 1) ? 5'd1 : rd;
        return {($urandom_range(0, 4) == 0) ? 12'd4 : 12'd0, rs1, 3'b000, rd, 7'h67};
      end
      7: return 32'h0010_0073;
      8: return {r[31:12], rd, 7'h37};
      9: return {r[31:12], rd, 7'h17};
      10: return {r[31:12], rd, 7'h6F};
      default: return {r[31:25], rs2, rs1, 3'b000, r[11:7], 7'h63};
    endcase
  endfunction

  // Offer one instruction; starts and ends just after a falling edge.
  task automatic send(input logic [31:0] ins);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    instr_valid = 1'b1;
    instr = ins;
    while (!acc && n < 500) begin
      #4;
      acc = instr_ready;
      @(negedge clk);
      n++;
    end
    instr_valid = 1'b0;
    total++;
    if (!acc) $display("FAIL send_timeout: instr %08h accepted=%0b required=1", ins, acc);
    else passed++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #4;
    total++; if (word_valid !== 1'b0) $display("FAIL reset_word_valid: got %0b want 0", word_valid); else passed++;
    total++; if (word !== 32'h0) $display("FAIL reset_word: got %08h want 00000000", word); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else passed++;
`ifdef IBEX_CENC_STATS_EN
    total++; if (stat_total !== 32'h0 || stat_comp !== 32'h0)
      $display("FAIL reset_stats: got %0d/%0d want 0/0", stat_total, stat_comp); else passed++;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #4;
    total++; if (instr_ready !== 1'b1) $display("FAIL reset_ready: got %0b want 1", instr_ready); else passed++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    got.delete();
    word_ready = 1'b1;
    send(32'h0014_0413);
    send(32'h0014_0413);
    #4;
    total++; if (word_valid !== 1'b0) $display("FAIL b2b_early: word_valid got %0b want 0", word_valid); else passed++;
    @(negedge clk);
    #4;
    total++; if (word_valid !== 1'b1 || word !== 32'h0405_0405)
      $display("FAIL b2b_word: valid %0b word %08h want 1 04050405", word_valid, word); else passed++;
    @(negedge clk);
    total++; if (got.size() != 1 || busy !== 1'b0)
      $display("FAIL b2b_count: words %0d busy %0b want 1 0", got.size(), busy); else passed++;
  endtask

  task automatic test_lui();
    got.delete();
    send(32'h1234_52B7);
    repeat (3) @(negedge clk);
    total++; if (got.size() != 1 || got[0] !== 32'h1234_52B7)
      $display("FAIL lui_word: words %0d first %08h want 1 123452b7", got.size(), (got.size() > 0) ? got[0] : 32'h0);
    else passed++;
  endtask

  task automatic test_flush();
    int n;
    got.delete();
    send(32'h0014_0413);
    send(32'h1234_52B7);
    flush = 1'b1;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    flush = 1'b0;
    total++; if (n >= 50) $display("FAIL flush_timeout: busy %0b want 0", busy); else passed++;
    total++; if (got.size() != 2 || got[0] !== 32'h52B7_0405 || got[1] !== 32'h0001_1234)
      $display("FAIL flush_words: count %0d first %08h last %08h want 2 52b70405 00011234",
               got.size(), (got.size() > 0) ? got[0] : 32'h0, (got.size() > 1) ? got[1] : 32'h0);
    else passed++;
    #4;
    total++; if (busy !== 1'b0) $display("FAIL flush_busy: got %0b want 0", busy); else passed++;
    @(negedge clk);
  endtask

  task automatic test_lw_ebreak();
    got.delete();
    send(32'h0085_2483);
    send(32'h0010_0073);
    repeat (3) @(negedge clk);
    total++; if (got.size() != 1 || got[0] !== 32'h9002_4504)
      $display("FAIL lw_ebreak_word: words %0d first %08h want 1 90024504", got.size(), (got.size() > 0) ? got[0] : 32'h0);
    else passed++;
  endtask

  task automatic test_passthrough();
    got.delete();
    send(32'h0000_0001);
    send(32'hABCD_4505);
    repeat (3) @(negedge clk);
    total++; if (got.size() != 1 || got[0] !== 32'h4505_0001)
      $display("FAIL passthrough_word: words %0d first %08h want 1 45050001", got.size(), (got.size() > 0) ? got[0] : 32'h0);
    else passed++;
  endtask

  task automatic test_flush_empty();
    got.delete();
    flush = 1'b1;
    repeat (4) @(negedge clk);
    flush = 1'b0;
    #4;
    total++; if (got.size() != 0 || busy !== 1'b0)
      $display("FAIL flush_empty: words %0d busy %0b want 0 0", got.size(), busy); else passed++;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] stim[$];
    logic [15:0] hw[$];
    bit          done;
    int          n16, n32, pad;
    done = 1'b0;
    n16 = 0;
    n32 = 0;
    got.delete();
    for (int i = 0; i < 200; i++) stim.push_back(gen_instr());
    fork
      begin
        int n;
        foreach (stim[i]) send(stim[i]);
        flush = 1'b1;
        n = 0;
        while (busy && n < 300) begin
          @(negedge clk);
          n++;
        end
        flush = 1'b0;
        total++; if (n >= 300) $display("FAIL random_drain_timeout: busy %0b want 0", busy); else passed++;
        done = 1'b1;
      end
      begin
        int burst, stall_run;
        burst = 0;
        stall_run = 0;
        while (!done) begin
          if (burst > 0) begin
            word_ready = 1'b0;
            burst--;
          end else if ($urandom_range(0, 7) == 0) begin
            word_ready = 1'b0;
            burst = 4;
          end else begin
            word_ready = 1'b1;
          end
          #4;
          if (word_valid && !word_ready) stall_run++; else stall_run = 0;
          if (stall_run >= 3 && instr_valid) begin
            total++;
            if (instr_ready !== 1'b0) $display("FAIL stall_ready: instr_ready %0b want 0", instr_ready);
            else passed++;
          end
          @(negedge clk);
        end
        word_ready = 1'b1;
      end
    join
    foreach (got[i]) begin
      hw.push_back(got[i][15:0]);
      hw.push_back(got[i][31:16]);
    end
    foreach (stim[i]) begin
      logic [15:0] lo;
      logic [31:0] rebuilt;
      bit          c;
      if (hw.size() == 0) begin
        total++;
        $display("FAIL random_short: stream ended at instr %0d of 200", i);
        break;
      end
      lo = hw.pop_front();
      if (lo[1:0] != 2'b11) begin
        c = 1'b1;
        rebuilt = expand16(lo);
      end else begin
        c = 1'b0;
        if (hw.size() == 0) begin
          total++;
          $display("FAIL random_short: upper half missing at instr %0d", i);
          break;
        end
        rebuilt = {hw.pop_front(), lo};
      end
      if (c) n16++; else n32++;
      total++;
      if (c !== eligible(stim[i]) || rebuilt !== stim[i])
        $display("FAIL random_instr[%0d]: got %08h compressed=%0b want %08h compressed=%0b",
                 i, rebuilt, c, stim[i], eligible(stim[i]));
      else passed++;
    end
    pad = n16 % 2;
    total++;
    if (hw.size() != pad || (pad == 1 && hw[0] !== 16'h0001))
      $display("FAIL random_pad: leftover halfwords %0d want %0d (c.nop)", hw.size(), pad);
    else passed++;
  endtask

  task automatic test_reset_mid();
    got.delete();
    word_ready = 1'b0;
    send(32'h1234_52B7);
    send(32'h0014_0413);
    @(negedge clk);
    #4;
    total++; if (word_valid !== 1'b1 || busy !== 1'b1)
      $display("FAIL midrst_pre: valid %0b busy %0b want 1 1", word_valid, busy); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if (word_valid !== 1'b0 || word !== 32'h0 || busy !== 1'b0 || instr_ready !== 1'b1)
      $display("FAIL midrst_outputs: valid %0b word %08h busy %0b ready %0b want 0 00000000 0 1",
               word_valid, word, busy, instr_ready);
    else passed++;
`ifdef IBEX_CENC_STATS_EN
    total++; if (stat_total !== 32'h0 || stat_comp !== 32'h0)
      $display("FAIL midrst_stats: got %0d/%0d want 0/0", stat_total, stat_comp); else passed++;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    word_ready = 1'b1;
    @(negedge clk);
    send(32'h1234_52B7);
    repeat (3) @(negedge clk);
    total++; if (got.size() != 1 || got[0] !== 32'h1234_52B7)
      $display("FAIL midrst_after: words %0d first %08h want 1 123452b7", got.size(), (got.size() > 0) ? got[0] : 32'h0);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_lui();
    test_flush();
    test_lw_ebreak();
    test_passthrough();
    test_flush_empty();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
